// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath widths, ALU/operand-select encodings,
// and the ID/EX latch bundle.
package cpu_types_pkg;

    localparam int WORD_W  = 32;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [REG_W-1:0]   regbits_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        OP_RT    = 2'd0,
        OP_IMM   = 2'd1,
        OP_SHAMT = 2'd2
    } opsel_t;

    typedef struct packed {
        logic     valid;
        aluop_t   alu_op;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        shamt_t   shamt;
        regbits_t rs;
        regbits_t rt;
        regbits_t wsel;
        opsel_t   alusrc;
        logic     regwen;
    } id_ex_t;

    // A live source register matches an in-flight writer (r0 never does).
    function automatic logic reg_match(
        input logic     valid,
        input regbits_t src,
        input logic     wen,
        input regbits_t wsel
    );
        return valid && (src != '0) && wen && (wsel == src);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Per-operand hazard resolver: writer match, forward mux, stall detect.
// ID_EX_FWD_EN selects forwarding; otherwise every hazard stalls.
module fwd_select
    import cpu_types_pkg::*;
(
    input  logic     valid,
    input  regbits_t src,
    input  word_t    rdat,
    input  logic     exmem_regwen,
    input  logic     exmem_load,
    input  regbits_t exmem_wsel,
    input  word_t    exmem_result,
    input  logic     memwb_regwen,
    input  regbits_t memwb_wsel,
    input  word_t    memwb_wdat,
    output word_t    fwd,
    output logic     stall,
    output logic     wb_hit
);

    logic ex_hit;

    assign ex_hit = reg_match(valid, src, exmem_regwen, exmem_wsel);
    assign wb_hit = reg_match(valid, src, memwb_regwen, memwb_wsel);

`ifdef ID_EX_FWD_EN
    // Youngest writer wins: EX/MEM ahead of MEM/WB ahead of regfile.
    always_comb begin
        fwd = rdat;
        if (ex_hit)
            fwd = exmem_result;
        else if (wb_hit)
            fwd = memwb_wdat;
    end

    assign stall = ex_hit & exmem_load;
`else
    logic unused_fwd;

    assign unused_fwd = ^{exmem_load, exmem_result};
    assign fwd        = rdat;
    assign stall      = ex_hit | wb_hit;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX latch with operand selection feeding the ALU.
// Build with ID_EX_FWD_EN for EX/MEM and MEM/WB forwarding.
module id_ex_operand_stage
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    input  logic [WORD_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic [1:0]        id_alusrc,
    input  logic              id_regwen,
    input  logic              exmem_regwen,
    input  logic              exmem_load,
    input  logic [REG_W-1:0]  exmem_wsel,
    input  logic [WORD_W-1:0] exmem_result,
    input  logic              memwb_regwen,
    input  logic [REG_W-1:0]  memwb_wsel,
    input  logic [WORD_W-1:0] memwb_wdat,
    output logic [3:0]        alu_op,
    output logic [WORD_W-1:0] port_a,
    output logic [WORD_W-1:0] port_b,
    output logic              ex_valid,
    output logic              ex_regwen,
    output logic [REG_W-1:0]  ex_wsel,
    output logic [WORD_W-1:0] ex_store,
    output logic              stall_req
);

    id_ex_t q;
    id_ex_t d;
    word_t  fwd1;
    word_t  fwd2;
    logic   stall1;
    logic   stall2;
    logic   wb_hit1;
    logic   wb_hit2;

    fwd_select u_fwd_rs (
        .valid        (q.valid),
        .src          (q.rs),
        .rdat         (q.rdat1),
        .exmem_regwen (exmem_regwen),
        .exmem_load   (exmem_load),
        .exmem_wsel   (exmem_wsel),
        .exmem_result (exmem_result),
        .memwb_regwen (memwb_regwen),
        .memwb_wsel   (memwb_wsel),
        .memwb_wdat   (memwb_wdat),
        .fwd          (fwd1),
        .stall        (stall1),
        .wb_hit       (wb_hit1)
    );

    fwd_select u_fwd_rt (
        .valid        (q.valid),
        .src          (q.rt),
        .rdat         (q.rdat2),
        .exmem_regwen (exmem_regwen),
        .exmem_load   (exmem_load),
        .exmem_wsel   (exmem_wsel),
        .exmem_result (exmem_result),
        .memwb_regwen (memwb_regwen),
        .memwb_wsel   (memwb_wsel),
        .memwb_wdat   (memwb_wdat),
        .fwd          (fwd2),
        .stall        (stall2),
        .wb_hit       (wb_hit2)
    );

    assign stall_req = stall1 | stall2;

    // Pack the decode slot into the latch bundle.
    always_comb begin
        d        = '0;
        d.valid  = id_valid;
        d.alu_op = aluop_t'(id_alu_op);
        d.rdat1  = id_rdat1;
        d.rdat2  = id_rdat2;
        d.imm    = id_imm;
        d.shamt  = id_shamt;
        d.rs     = id_rs;
        d.rt     = id_rt;
        d.wsel   = id_wsel;
        d.alusrc = opsel_t'(id_alusrc);
        d.regwen = id_regwen;
    end

    // Latch update: flush > hold (refresh retiring operands) > advance.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (stall_req) begin
            if (wb_hit1)
                q.rdat1 <= memwb_wdat;
            if (wb_hit2)
                q.rdat2 <= memwb_wdat;
        end else if (en) begin
            q <= d;
        end
    end

    // Route shift amount / immediate onto the ALU ports.
    always_comb begin
        port_a = fwd1;
        port_b = fwd2;
        case (q.alusrc)
            OP_SHAMT: port_a = {{(WORD_W-SHAMT_W){1'b0}}, q.shamt};
            OP_IMM:   port_b = q.imm;
            default:  ;
        endcase
    end

    assign alu_op    = q.alu_op;
    assign ex_store  = fwd2;
    assign ex_wsel   = q.wsel;
    assign ex_valid  = q.valid & ~stall_req;
    assign ex_regwen = q.valid & q.regwen & ~stall_req;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage.
// Expectations adapt to whether ID_EX_FWD_EN is defined.
module tb_id_ex_operand_stage;
    import cpu_types_pkg::*;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        en;
    logic        flush;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    word_t       id_rdat1;
    word_t       id_rdat2;
    word_t       id_imm;
    logic [4:0]  id_shamt;
    regbits_t    id_rs;
    regbits_t    id_rt;
    regbits_t    id_wsel;
    logic [1:0]  id_alusrc;
    logic        id_regwen;
    logic        exmem_regwen;
    logic        exmem_load;
    regbits_t    exmem_wsel;
    word_t       exmem_result;
    logic        memwb_regwen;
    regbits_t    memwb_wsel;
    word_t       memwb_wdat;
    logic [3:0]  alu_op;
    word_t       port_a;
    word_t       port_b;
    logic        ex_valid;
    logic        ex_regwen;
    regbits_t    ex_wsel;
    word_t       ex_store;
    logic        stall_req;

    typedef struct {
        string    tag;
        logic [3:0] op;
        word_t    a;
        word_t    b;
        word_t    st;
        logic     v;
        logic     rw;
        regbits_t ws;
        logic     stl;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 CLK = ~CLK;

    id_ex_operand_stage dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .en           (en),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_alu_op    (id_alu_op),
        .id_rdat1     (id_rdat1),
        .id_rdat2     (id_rdat2),
        .id_imm       (id_imm),
        .id_shamt     (id_shamt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_wsel      (id_wsel),
        .id_alusrc    (id_alusrc),
        .id_regwen    (id_regwen),
        .exmem_regwen (exmem_regwen),
        .exmem_load   (exmem_load),
        .exmem_wsel   (exmem_wsel),
        .exmem_result (exmem_result),
        .memwb_regwen (memwb_regwen),
        .memwb_wsel   (memwb_wsel),
        .memwb_wdat   (memwb_wdat),
        .alu_op       (alu_op),
        .port_a       (port_a),
        .port_b       (port_b),
        .ex_valid     (ex_valid),
        .ex_regwen    (ex_regwen),
        .ex_wsel      (ex_wsel),
        .ex_store     (ex_store),
        .stall_req    (stall_req)
    );

    task automatic check(input string tag, input word_t got,
                         input word_t want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic expect_out(input string tag, input aluop_t op,
                              input word_t a, input word_t b,
                              input word_t st, input logic v,
                              input logic rw, input regbits_t ws,
                              input logic stl);
        exp_t e;
        e.tag = tag; e.op = op; e.a = a; e.b = b; e.st = st;
        e.v = v; e.rw = rw; e.ws = ws; e.stl = stl;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".alu_op"}, 32'(alu_op), 32'(e.op));
            check({e.tag, ".port_a"}, port_a, e.a);
            check({e.tag, ".port_b"}, port_b, e.b);
            check({e.tag, ".store"}, ex_store, e.st);
            check({e.tag, ".valid"}, 32'(ex_valid), 32'(e.v));
            check({e.tag, ".regwen"}, 32'(ex_regwen), 32'(e.rw));
            check({e.tag, ".wsel"}, 32'(ex_wsel), 32'(e.ws));
            check({e.tag, ".stall"}, 32'(stall_req), 32'(e.stl));
        end
    endtask

    task automatic tick();
        compare_out();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_id(input aluop_t op, input regbits_t rs,
                          input word_t r1, input regbits_t rt,
                          input word_t r2, input word_t imm,
                          input logic [4:0] sh, input opsel_t src,
                          input regbits_t ws);
        id_valid  = 1'b1;
        id_alu_op = op;
        id_rs     = rs;
        id_rdat1  = r1;
        id_rt     = rt;
        id_rdat2  = r2;
        id_imm    = imm;
        id_shamt  = sh;
        id_alusrc = src;
        id_regwen = 1'b1;
        id_wsel   = ws;
    endtask

    task automatic set_haz(input logic xr, input logic xl,
                           input regbits_t xw, input word_t xd,
                           input logic wr, input regbits_t ww,
                           input word_t wd);
        exmem_regwen = xr;
        exmem_load   = xl;
        exmem_wsel   = xw;
        exmem_result = xd;
        memwb_regwen = wr;
        memwb_wsel   = ww;
        memwb_wdat   = wd;
    endtask

    initial begin
        nRST = 1'b0; en = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_alu_op = '0; id_rdat1 = '0; id_rdat2 = '0;
        id_imm = '0; id_shamt = '0; id_rs = '0; id_rt = '0;
        id_wsel = '0; id_alusrc = '0; id_regwen = 1'b0;
        set_haz(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        expect_out("reset", ALU_SLL, 0, 0, 0, 0, 0, 0, 0);
        set_id(ALU_ADD, 1, 32'h5, 2, 32'h7, 0, 0, OP_RT, 8);
        en = 1'b1;
        tick();

        expect_out("add", ALU_ADD, 32'h5, 32'h7, 32'h7, 1, 1, 8, 0);
        set_id(ALU_OR, 3, 32'h0, 5, 32'h55, 0, 0, OP_RT, 9);
        tick();

        en = 1'b0;
        set_haz(1, 0, 3, 32'h1234, 1, 3, 32'h9999);
        expect_out("exmem_fwd", ALU_OR, FWD ? 32'h1234 : 32'h0,
                   32'h55, 32'h55, FWD, FWD, 9, !FWD);
        tick();

        en = 1'b1;
        set_haz(0, 0, 0, 0, 0, 0, 0);
        expect_out("after_fwd", ALU_OR, FWD ? 32'h0 : 32'h9999,
                   32'h55, 32'h55, 1, 1, 9, 0);
        set_id(ALU_ADD, 6, 32'h66, 4, 32'h11, 0, 0, OP_RT, 10);
        tick();

        set_haz(1, 1, 4, 32'h77, 1, 6, 32'hCAFE);
        expect_out("load_use", ALU_ADD, FWD ? 32'hCAFE : 32'h66,
                   FWD ? 32'h77 : 32'h11, FWD ? 32'h77 : 32'h11,
                   0, 0, 10, 1);
        set_id(ALU_SLL, 0, 32'h0, 7, 32'h1, 0, 5, OP_SHAMT, 11);
        tick();

        en = 1'b0;
        set_haz(0, 0, 0, 0, 1, 4, 32'hBEEF);
        expect_out("wb_fwd", ALU_ADD, 32'hCAFE,
                   FWD ? 32'hBEEF : 32'h11, FWD ? 32'hBEEF : 32'h11,
                   FWD, FWD, 10, !FWD);
        tick();

        en = 1'b1;
        set_haz(0, 0, 0, 0, 0, 0, 0);
        expect_out("resume", ALU_ADD, 32'hCAFE,
                   FWD ? 32'h11 : 32'hBEEF, FWD ? 32'h11 : 32'hBEEF,
                   1, 1, 10, 0);
        tick();

        expect_out("sll", ALU_SLL, 32'h5, 32'h1, 32'h1, 1, 1, 11, 0);
        set_id(ALU_OR, 0, 32'h3, 13, 32'h22, 32'hFF, 0, OP_IMM, 12);
        tick();

        set_haz(1, 1, 0, 32'hDEAD, 1, 0, 32'h1);
        expect_out("ori_r0", ALU_OR, 32'h3, 32'hFF, 32'h22, 1, 1, 12, 0);
        set_id(ALU_SUB, 15, 32'h55, 14, 32'h44, 0, 0, OP_RT, 16);
        tick();

        set_haz(1, 1, 14, 32'h9, 0, 0, 0);
        flush = 1'b1;
        expect_out("flush_stall", ALU_SUB, 32'h55,
                   FWD ? 32'h9 : 32'h44, FWD ? 32'h9 : 32'h44,
                   0, 0, 16, 1);
        set_id(ALU_AND, 1, 32'hF0, 2, 32'h0F, 0, 0, OP_RT, 17);
        tick();

        flush = 1'b0;
        expect_out("flushed", ALU_SLL, 0, 0, 0, 0, 0, 0, 0);
        tick();

        set_haz(0, 0, 0, 0, 0, 0, 0);
        expect_out("and", ALU_AND, 32'hF0, 32'h0F, 32'h0F, 1, 1, 17, 0);
        tick();

        en = 1'b0;
        set_haz(1, 1, 1, 32'h0, 0, 0, 0);
        expect_out("pre_rst", ALU_AND, FWD ? 32'h0 : 32'hF0,
                   32'h0F, 32'h0F, 0, 0, 17, 1);
        compare_out();
        #1 nRST = 1'b0;
        expect_out("rst_mid", ALU_SLL, 0, 0, 0, 0, 0, 0, 0);
        compare_out();

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register with operand selection. Sits directly upstream of the ALU and drives its alu_op, port_a and port_b.
- Latches decoded fields from decode and resolves data hazards against the EX/MEM and MEM/WB stages, either by forwarding or by requesting a stall.
- Produces store data and write-back tags for the EX/MEM latch downstream.

Parameters:
- WORD_W, 32, datapath width (taken from cpu_types_pkg)
- REG_W, 5, register index width

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- en  in  1  hazard-unit advance enable
- flush  in  1  squash latched instruction (branch/jump mispredict)
- id_valid  in  1  decode slot holds a real instruction
- id_alu_op  in  4  aluop_t
- id_rdat1, id_rdat2  in  WORD_W  register-file read data for rs, rt
- id_imm  in  WORD_W  extended immediate
- id_shamt  in  5  shift amount
- id_rs, id_rt, id_wsel  in  REG_W  source and destination indices
- id_alusrc  in  2  opsel_t: OP_RT=0, OP_IMM=1, OP_SHAMT=2
- id_regwen  in  1  instruction writes a register
- exmem_regwen, exmem_load  in  1  EX/MEM writer valid; writer is a load
- exmem_wsel  in  REG_W
- exmem_result  in  WORD_W
- memwb_regwen  in  1
- memwb_wsel  in  REG_W
- memwb_wdat  in  WORD_W
- alu_op  out  4  to ALU
- port_a, port_b  out  WORD_W  to ALU
- ex_valid, ex_regwen  out  1
- ex_wsel  out  REG_W
- ex_store  out  WORD_W  forwarded rt value
- stall_req  out  1  hold decode/fetch

Behaviour:
- Latch state: valid, alu_op, rdat1, rdat2, imm, shamt, rs, rt, wsel, alusrc, regwen.
- Reset: all latch fields 0. Outputs therefore reset to alu_op=ALU_SLL(0), port_a=0, port_b=0, ex_valid=0, ex_regwen=0, ex_wsel=0, ex_store=0, stall_req=0.
- Edge update priority (posedge CLK): flush > hold > en > keep.
  - flush: clear valid and regwen; other fields don't-care, implementation zeros them.
  - hold (stall_req=1): keep all fields, except rdat1/rdat2 capture memwb_wdat when memwb_regwen and memwb_wsel matches rs/rt (nonzero). This refreshes stale values that the register file retires during the stall.
  - en=1 and no hold: load all id_* fields.
  - en=0 and no hold: keep.
- Match condition: src!=0 and writer regwen and writer wsel==src. This applies only when the latch valid=1.
- Operand resolution (combinational from latch):
  - fwd1 = exmem_result if EX/MEM matches rs; else memwb_wdat if MEM/WB matches rs; else rdat1.
  - fwd2 is the same rule applied to rt.
  - EX/MEM has priority over MEM/WB.
- Operand routing:
  - port_a = {27'b0, shamt} when alusrc=OP_SHAMT, else fwd1.
  - port_b = imm when alusrc=OP_IMM, else fwd2.
  - ex_store = fwd2.
- Load-use: when EX/MEM matches rs or rt and exmem_load=1, stall_req=1.
- Bubble insertion: when stall_req=1, ex_valid=0 and ex_regwen=0. This inserts a bubble for that cycle, so downstream never sees a duplicate.
- Flush versus stall: flush in the same cycle as stall_req clears the latch and drops the stall on the next cycle.
- Reset mid-stall: asynchronous clear; stall_req drops immediately.
- Register 0 is never forwarded and never stalls.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding as above. Stall only on load-use.
- Undefined: no forwarding; fwd1=rdat1, fwd2=rdat2. stall_req=1 whenever EX/MEM or MEM/WB matches rs or rt (loads included). Hold-cycle memwb capture stays active, so the instruction resumes with correct values.

Decomposition:
- cpu_types_pkg additions:
  - opsel_t enum (OP_RT, OP_IMM, OP_SHAMT).
  - id_ex_t packed struct for the latch contents.
  - Reuse existing aluop_t, word_t, regbits_t.
- One sub-module: fwd_select, a combinational per-operand priority mux plus match/stall detect. It is instantiated twice (rs, rt).

Test Plan:
- Reset: nRST=0 mid-cycle → all outputs 0 immediately. After release with en=1, ADD rs=1 (rdat1=5), rt=2 (rdat2=7) → next cycle alu_op=ALU_ADD, port_a=5, port_b=7, ex_valid=1.
- EX/MEM forward (ID_EX_FWD_EN): latched rs=3 (rdat1=0), exmem_regwen=1, exmem_wsel=3, exmem_result=0x1234, and memwb also writing r3=0x9999 → port_a=0x1234, stall_req=0.
- Load-use: exmem_load=1, exmem_wsel=rt=4 → stall_req=1, ex_valid=0 for one cycle. Next cycle memwb_wsel=4, memwb_wdat=0xBEEF → port_b=0xBEEF, ex_valid=1.
- Shift and immediate routing: SLL with shamt=5, rt value 0x1 → port_a=5, port_b=1. ORI with imm=0xFF → port_b=0xFF.
- Register zero: rs=0, exmem_wsel=0, exmem_regwen=1, exmem_result=0xDEAD → port_a=rdat1, stall_req=0.
- Flush during stall: stall_req=1 and flush=1 → next cycle ex_valid=0, stall_req=0. Macro undefined: memwb match on rt → stall_req=1 for 1 cycle, then captured value on port_b.
